// File: rtl/n5_uart_pkg.sv
// Shared UART TX definitions: FSM state encoding and frame constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package n5_uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_e;
`endif

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte FIFO feeding the UART transmitter. Pointers carry one extra wrap bit,
// so full/empty/level come straight from the registered pointers.
module uart_tx_fifo_mem #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             wdata,
    input  logic                   pop,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        overflow_q, overflow_d;
    logic        do_push, do_pop;

    assign level    = wptr_q - rptr_q;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign rdata    = mem_q[rptr_q[AW-1:0]];
    assign overflow = overflow_q;

    // A push into a full FIFO still lands if the head leaves on the same edge.
    assign do_pop     = pop & ~empty;
    assign do_push    = push & (~full | do_pop);
    assign wptr_d     = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d     = do_pop  ? rptr_q + 1'b1 : rptr_q;
    assign overflow_d = push & ~do_push;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO: 8N1 framing, or 8E1 when UART_TX_PARITY_EN
// is defined. Bit time is prescaler+1 HCLK cycles, latched at each frame start.
module uart_tx_fifo
    import n5_uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PRESCALE_W = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   en,
    input  logic [PRESCALE_W-1:0]  prescaler,
    input  logic                   wr,
    input  logic [7:0]             wdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy,
    output logic                   tx
);

    state_e                state_q, state_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [2:0]            bitidx_q, bitidx_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic       pop, bit_end, load;
    logic [7:0] rdata;

    uart_tx_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .push     (wr),
        .wdata    (wdata),
        .pop      (pop),
        .rdata    (rdata),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    assign bit_end = (cnt_q == presc_q);
    // A frame starts from IDLE or directly out of the last STOP cycle.
    assign load    = en & ~empty &
                     ((state_q == IDLE) | ((state_q == STOP) & bit_end));
    assign pop     = load;
    assign busy    = (state_q != IDLE);
    assign tx      = tx_q;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        presc_d  = presc_q;
        cnt_d    = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
        bitidx_d = bitidx_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (bit_end) begin
            case (state_q)
                START: begin
                    cnt_d    = '0;
                    state_d  = DATA;
                    bitidx_d = '0;
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                end
                DATA: begin
                    cnt_d = '0;
                    if (bitidx_q == 3'(DATA_BITS-1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = IDLE_LEVEL;
`endif
                    end else begin
                        bitidx_d = bitidx_q + 1'b1;
                        tx_d     = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = IDLE_LEVEL;
                end
`endif
                STOP: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                end
                default: ;
            endcase
        end
        if (load) begin
            state_d = START;
            shreg_d = rdata;
            presc_d = prescaler;
            cnt_d   = '0;
            tx_d    = ~IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_d   = ^rdata;
`endif
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            bitidx_q <= '0;
            tx_q     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; expected bytes queue up when pushed and are
// matched against decoded serial frames. Honors UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        en = 1'b0;
    logic [15:0] prescaler = '0;
    logic        wr = 1'b0;
    logic [7:0]  wdata = '0;
    logic        full, empty, overflow, busy, tx;
    logic [4:0]  level;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];

    uart_tx_fifo #(.DEPTH(16), .PRESCALE_W(16)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .en        (en),
        .prescaler (prescaler),
        .wr        (wr),
        .wdata     (wdata),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .busy      (busy),
        .tx        (tx)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_kept);
        wr    = 1'b1;
        wdata = b;
        if (expect_kept) exp_q.push_back(b);
        tick();
        wr = 1'b0;
    endtask

    task automatic wait_start(input int max, input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        chk({tag, " start seen"}, 32'(tx), 32'd0);
    endtask

    // Called on cycle 0 of a start bit; returns on the first cycle after STOP.
    // At the start of bit drop_bit, en is dropped and the prescaler changed.
    task automatic check_frame(input int p, input int drop_bit, input string tag);
        logic [7:0]       b;
        logic [7:0]       rx;
        logic [NBITS-1:0] seq;
        int               bad;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=frame expected=no byte queued", tag);
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
`ifdef UART_TX_PARITY_EN
        seq = {1'b1, ^b, b, 1'b0};
`else
        seq = {1'b1, b, 1'b0};
`endif
        rx = '0;
        for (int i = 0; i < NBITS; i++) begin
            bad = 0;
            for (int c = 0; c <= p; c++) begin
                if (i == drop_bit && c == 0) begin
                    en        = 1'b0;
                    prescaler = 16'd7;
                end
                if (tx !== seq[i]) bad++;
                if (i >= 1 && i <= 8 && c == p / 2) rx[i-1] = tx;
                tick();
            end
            chk($sformatf("%s bit%0d", tag, i), 32'(bad), 32'd0);
        end
        chk({tag, " rx byte"}, 32'(rx), 32'(b));
        $display("serial monitor rx char '%c' (0x%02h)", rx, rx);
    endtask

    initial begin
        int bad;

        // Reset state
        #2 HRESETn = 1'b0;
        #10;
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst level", 32'(level), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        HRESETn = 1'b1;
        tick();

        // 'H' at prescaler 15: tx low exactly one edge after the push
        en        = 1'b1;
        prescaler = 16'd15;
        push(8'h48, 1'b1);
        chk("push edge tx", 32'(tx), 32'd1);
        tick();
        chk("k+1 busy", 32'(busy), 32'd1);
        check_frame(15, -1, "H");
        chk("H done busy", 32'(busy), 32'd0);
        chk("H done tx", 32'(tx), 32'd1);
        chk("H done empty", 32'(empty), 32'd1);

        // Fill to full with en low, 17th push dropped
        en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(8'hA0 + 8'(i), i < 16);
            if (i == 15) begin
                chk("fill full", 32'(full), 32'd1);
                chk("fill level", 32'(level), 32'd16);
                chk("fill no ovf", 32'(overflow), 32'd0);
            end
        end
        chk("drop ovf", 32'(overflow), 32'd1);
        chk("drop level", 32'(level), 32'd16);
        // Push while full but popping on the same edge is accepted
        prescaler = 16'd0;
        en        = 1'b1;
        push(8'h5A, 1'b1);
        chk("pushpop level", 32'(level), 32'd16);
        chk("ovf one pulse", 32'(overflow), 32'd0);
        chk("pushpop tx", 32'(tx), 32'd0);
        for (int i = 0; i < 17; i++) check_frame(0, -1, $sformatf("drain%0d", i));
        chk("drain empty", 32'(empty), 32'd1);
        chk("drain busy", 32'(busy), 32'd0);

        // Three back-to-back 40-cycle frames
        en        = 1'b0;
        prescaler = 16'd3;
        push(8'h31, 1'b1);
        push(8'h07, 1'b1);
        push(8'hC5, 1'b1);
        en = 1'b1;
        wait_start(4, "b2b");
        for (int i = 0; i < 3; i++) check_frame(3, -1, $sformatf("b2b%0d", i));
        chk("b2b busy", 32'(busy), 32'd0);
        chk("b2b empty", 32'(empty), 32'd1);

        // en dropped during data bit 3: frame completes, nothing new starts
        en = 1'b0;
        push(8'h96, 1'b1);
        push(8'h3C, 1'b1);
        en = 1'b1;
        wait_start(4, "endrop");
        check_frame(3, 4, "endrop");
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (tx !== 1'b1) bad++;
            tick();
        end
        chk("endrop tx idle", 32'(bad), 32'd0);
        chk("endrop busy", 32'(busy), 32'd0);
        chk("endrop level", 32'(level), 32'd1);
        en = 1'b1;
        wait_start(4, "newpresc");
        check_frame(7, -1, "newpresc");

        // Async reset mid-DATA
        prescaler = 16'd3;
        push(8'h55, 1'b1);
        for (int c = 0; c < 9; c++) tick();
        chk("pre-rst busy", 32'(busy), 32'd1);
        #3 HRESETn = 1'b0;
        #1;
        chk("async rst tx", 32'(tx), 32'd1);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst level", 32'(level), 32'd0);
        chk("async rst empty", 32'(empty), 32'd1);
        exp_q.delete();
        #2 HRESETn = 1'b1;
        tick();
        tick();
        chk("post rst tx", 32'(tx), 32'd1);
        chk("post rst busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
